// File: rtl/vga_display_timing_gen_if.sv
// Raster timing bundle from the display timing generator
// to the scaler and colorizer.
interface vga_display_timing_gen_if;
    logic        horiz_sync;
    logic        vert_sync;
    logic        video_on;
    logic        frame_start;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;

    modport master (
        output horiz_sync, vert_sync, video_on,
        output frame_start, pixel_row, pixel_column
    );

    modport slave (
        input horiz_sync, vert_sync, video_on,
        input frame_start, pixel_row, pixel_column
    );
endinterface

// File: rtl/vga_display_timing_gen.sv
// Free-running 1024x768@60 raster counter with registered,
// mutually aligned sync, blanking and coordinate outputs.
module vga_display_timing_gen #(
    parameter int   H_VISIBLE     = 1024,
    parameter int   H_FRONT       = 24,
    parameter int   H_SYNC        = 136,
    parameter int   H_BACK        = 160,
    parameter int   V_VISIBLE     = 768,
    parameter int   V_FRONT       = 3,
    parameter int   V_SYNC        = 6,
    parameter int   V_BACK        = 29,
    parameter logic H_SYNC_ACTIVE = 1'b0,
    parameter logic V_SYNC_ACTIVE = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    vga_display_timing_gen_if.master vga_o
);

    localparam logic [11:0] H_VIS   = 12'(H_VISIBLE);
    localparam logic [11:0] H_SY_LO = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] H_SY_HI = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] H_LAST  =
        12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [11:0] V_VIS   = 12'(V_VISIBLE);
    localparam logic [11:0] V_SY_LO = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] V_SY_HI = 12'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [11:0] V_LAST  =
        12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] row_q, col_q;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_q, video_d;
    logic        frame_q, frame_d;

    // Row advances only on the line wrap, so the corner wraps both at once.
    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
        end
    end

    always_comb begin
        video_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hsync_d = ((h_cnt_q >= H_SY_LO) && (h_cnt_q < H_SY_HI))
                ? H_SYNC_ACTIVE : ~H_SYNC_ACTIVE;
        vsync_d = ((v_cnt_q >= V_SY_LO) && (v_cnt_q < V_SY_HI))
                ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
        frame_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            video_q <= 1'b0;
            frame_q <= 1'b0;
            hsync_q <= ~H_SYNC_ACTIVE;
            vsync_q <= ~V_SYNC_ACTIVE;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            row_q   <= v_cnt_q;
            col_q   <= h_cnt_q;
            video_q <= video_d;
            frame_q <= frame_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga_o.horiz_sync   = hsync_q;
    assign vga_o.vert_sync    = vsync_q;
    assign vga_o.video_on     = video_q;
    assign vga_o.frame_start  = frame_q;
    assign vga_o.pixel_row    = row_q;
    assign vga_o.pixel_column = col_q;

endmodule

// File: tb/tb_vga_display_timing_gen.sv
// Directed checks of the raster generator: full-size timing on one
// instance, frame/corner/polarity behaviour on a tiny-raster instance.
module tb_vga_display_timing_gen;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_checks;
    int n_fails;

    vga_display_timing_gen_if vga_a ();
    vga_display_timing_gen_if vga_b ();

    vga_display_timing_gen dut_a (
        .clk   (clk),
        .reset (rst_a),
        .vga_o (vga_a.master)
    );

    // Tiny raster: 16 columns (sync 10..12), 8 rows (sync 5..6).
    vga_display_timing_gen #(
        .H_VISIBLE     (8),
        .H_FRONT       (2),
        .H_SYNC        (3),
        .H_BACK        (3),
        .V_VISIBLE     (4),
        .V_FRONT       (1),
        .V_SYNC        (2),
        .V_BACK        (1),
        .H_SYNC_ACTIVE (1'b1),
        .V_SYNC_ACTIVE (1'b1)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .vga_o (vga_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag,
                           input int col, input int row,
                           input logic vo, input logic fs,
                           input logic hs, input logic vs);
        check({tag, ".col"}, 32'(vga_a.pixel_column), 32'(col));
        check({tag, ".row"}, 32'(vga_a.pixel_row), 32'(row));
        check({tag, ".vo"}, 32'(vga_a.video_on), 32'(vo));
        check({tag, ".fs"}, 32'(vga_a.frame_start), 32'(fs));
        check({tag, ".hs"}, 32'(vga_a.horiz_sync), 32'(hs));
        check({tag, ".vs"}, 32'(vga_a.vert_sync), 32'(vs));
    endtask

    initial begin
        int hs_low, hs_first, hs_last, vo_fall, col_err;
        logic vo_prev;
        int fs_cnt, fs_k0, fs_k1, vs_cnt, vs_row0, vo_bad;
        int max_col, max_row, hs_hi, hs_first_b;

        n_checks = 0;
        n_fails  = 0;
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        #3;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check_a("rst_async", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        check_a("rst_held", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Release between edges; first edge must show pixel (0,0).
        @(negedge clk);
        rst_a = 1'b0;
        tick();
        check_a("first_edge", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);

        hs_low   = 0;
        hs_first = -1;
        hs_last  = -1;
        vo_fall  = -1;
        col_err  = 0;
        vo_prev  = vga_a.video_on;
        for (int k = 1; k < 1344; k++) begin
            tick();
            if (vga_a.pixel_column != 12'(k)) col_err++;
            if (vo_prev && !vga_a.video_on)
                vo_fall = int'(vga_a.pixel_column);
            if (!vga_a.horiz_sync) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(vga_a.pixel_column);
                hs_last = int'(vga_a.pixel_column);
            end
            vo_prev = vga_a.video_on;
        end
        check("line.col_seq_errors", 32'(col_err), 32'd0);
        check("line.vo_fall_col", 32'(vo_fall), 32'd1024);
        check("line.hs_low_clocks", 32'(hs_low), 32'd136);
        check("line.hs_first_col", 32'(hs_first), 32'd1048);
        check("line.hs_last_col", 32'(hs_last), 32'd1183);
        check("line.last_col", 32'(vga_a.pixel_column), 32'd1343);
        tick();
        check_a("line_wrap", 0, 1, 1'b1, 1'b0, 1'b1, 1'b1);

        // Advance to row 2, column 500 then reset mid-line.
        repeat (1344 + 500) tick();
        check_a("mid_pos", 500, 2, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        rst_a = 1'b1;
        #1;
        check_a("mid_rst", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst_a = 1'b0;
        tick();
        check_a("mid_restart", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check_a("mid_next", 1, 0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Tiny raster: reset levels with active-high sync.
        check("b.rst.hs", 32'(vga_b.horiz_sync), 32'd0);
        check("b.rst.vs", 32'(vga_b.vert_sync), 32'd0);
        check("b.rst.col", 32'(vga_b.pixel_column), 32'd0);
        check("b.rst.vo", 32'(vga_b.video_on), 32'd0);

        @(negedge clk);
        rst_b      = 1'b0;
        fs_cnt     = 0;
        fs_k0      = -1;
        fs_k1      = -1;
        vs_cnt     = 0;
        vs_row0    = -1;
        vo_bad     = 0;
        max_col    = 0;
        max_row    = 0;
        hs_hi      = 0;
        hs_first_b = -1;
        for (int k = 0; k < 260; k++) begin
            tick();
            if (vga_b.frame_start) begin
                fs_cnt++;
                if (fs_k0 < 0) fs_k0 = k;
                else if (fs_k1 < 0) fs_k1 = k;
            end
            if (k < 128 && vga_b.vert_sync) begin
                vs_cnt++;
                if (vs_row0 < 0) vs_row0 = int'(vga_b.pixel_row);
            end
            if (k < 16 && vga_b.horiz_sync) begin
                hs_hi++;
                if (hs_first_b < 0) hs_first_b = int'(vga_b.pixel_column);
            end
            if (vga_b.video_on && vga_b.pixel_row >= 12'd4) vo_bad++;
            if (int'(vga_b.pixel_column) > max_col)
                max_col = int'(vga_b.pixel_column);
            if (int'(vga_b.pixel_row) > max_row)
                max_row = int'(vga_b.pixel_row);
            if (k == 0) begin
                check("b.first.fs", 32'(vga_b.frame_start), 32'd1);
                check("b.first.vo", 32'(vga_b.video_on), 32'd1);
            end
            if (k == 127) begin
                check("b.corner.col", 32'(vga_b.pixel_column), 32'd15);
                check("b.corner.row", 32'(vga_b.pixel_row), 32'd7);
                check("b.corner.fs", 32'(vga_b.frame_start), 32'd0);
            end
            if (k == 128) begin
                check("b.wrap.col", 32'(vga_b.pixel_column), 32'd0);
                check("b.wrap.row", 32'(vga_b.pixel_row), 32'd0);
                check("b.wrap.fs", 32'(vga_b.frame_start), 32'd1);
            end
        end
        check("b.fs_count", 32'(fs_cnt), 32'd3);
        check("b.fs_first_k", 32'(fs_k0), 32'd0);
        check("b.fs_period", 32'(fs_k1 - fs_k0), 32'd128);
        check("b.vs_clocks", 32'(vs_cnt), 32'd32);
        check("b.vs_first_row", 32'(vs_row0), 32'd5);
        check("b.hs_clocks", 32'(hs_hi), 32'd3);
        check("b.hs_first_col", 32'(hs_first_b), 32'd10);
        check("b.vo_in_vblank", 32'(vo_bad), 32'd0);
        check("b.max_col", 32'(max_col), 32'd15);
        check("b.max_row", 32'(max_row), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
